trace_cmd_issuer: RTL and testbench

Upstream stage of the cache simulator top: accepts parsed trace commands (opcode n, 32-bit address) from the trace reader through a valid/ready handshake and buffers them in a small FIFO. It sequences each command into the lookup/update phasing the data cache, instruction cache, MESI FSM and LRU counter expect. It drives the instruction word fields, read_enable, write_enable and the LRU start pulse, and issues clear and print requests. This replaces hand-written phase stimulus in the top.

---
 rtl/trace_cmd_issuer.sv | 169 ++++++++++++++++
 tb/tb_trace_cmd_issuer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_cmd_issuer.sv
// Trace command issuer: buffers parsed trace commands in a small FIFO and sequences
// each one into the lookup/update, clear and print phasing expected by the caches, MESI FSM and LRU.
module trace_cmd_issuer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int INDEX_BITS  = 14,
  parameter int OFFSET_BITS = 6,
  parameter int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [3:0]             i_cmd_n,
  input  logic [31:0]            i_cmd_addr,
  output logic                   o_instr_valid,
  output logic [3:0]             o_instr_n,
  output logic [31:0]            o_instr_addr,
  output logic [TAG_BITS-1:0]    o_instr_tag,
  output logic [INDEX_BITS-1:0]  o_instr_index,
  output logic [OFFSET_BITS-1:0] o_instr_offset,
  output logic                   o_data_sel,
  output logic                   o_read_enable,
  output logic                   o_write_enable,
  output logic                   o_start,
  output logic                   o_clear_req,
  output logic                   o_print_req,
  output logic                   o_busy,
  output logic [15:0]            o_issued_count,
  output logic [7:0]             o_err_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_UPDATE, S_CLEAR, S_PRINT1, S_PRINT2
  } state_e;

  state_e                   r_state;
  logic [35:0]              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic                     r_cmd_ready;
  logic                     r_is_access;
  logic                     r_instr_valid, r_data_sel;
  logic                     r_read_enable, r_write_enable, r_start;
  logic                     r_clear_req, r_print_req;
  logic [3:0]               r_instr_n;
  logic [31:0]              r_instr_addr;
  logic [15:0]              r_issued_count;
  logic [7:0]               r_err_count;

  logic                     w_push, w_pop, w_final, w_head_legal;
  logic [3:0]               w_head_n;
  logic [31:0]              w_head_addr;
  logic [CNT_W-1:0]         w_count_next;

  // Ready is registered, so a full FIFO refuses a push even when it pops that same cycle.
  assign w_push       = i_cmd_valid & r_cmd_ready;
  assign w_final      = (r_state == S_UPDATE) | (r_state == S_CLEAR) | (r_state == S_PRINT2);
  assign w_pop        = (r_count != '0) & ((r_state == S_IDLE) | w_final);
  assign w_head_n     = r_mem[r_rd_ptr][35:32];
  assign w_head_addr  = r_mem[r_rd_ptr][31:0];
  assign w_head_legal = (w_head_n <= 4'd6) | (w_head_n == 4'd8) | (w_head_n == 4'd9);
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // NOTE: storage carries no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_cmd_n, i_cmd_addr};
  end

  // NOTE: every register is updated with <= so all blocks see pre-edge values consistently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_next;
      r_cmd_ready <= (w_count_next != CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_is_access    <= 1'b0;
      r_instr_valid  <= 1'b0;
      r_data_sel     <= 1'b0;
      r_read_enable  <= 1'b0;
      r_write_enable <= 1'b0;
      r_start        <= 1'b0;
      r_clear_req    <= 1'b0;
      r_print_req    <= 1'b0;
      r_instr_n      <= '0;
      r_instr_addr   <= '0;
      r_issued_count <= '0;
      r_err_count    <= '0;
    end else begin
      unique case (r_state)
        S_LOOKUP: begin
          r_state        <= S_UPDATE;
          r_read_enable  <= 1'b0;
          r_write_enable <= 1'b1;
          r_start        <= r_is_access;
        end
        S_PRINT1: r_state <= S_PRINT2;
        default: begin
          // Idle or final cycle: fall back to IDLE unless a buffered command takes over.
          r_state        <= S_IDLE;
          r_instr_valid  <= 1'b0;
          r_read_enable  <= 1'b0;
          r_write_enable <= 1'b0;
          r_start        <= 1'b0;
          r_clear_req    <= 1'b0;
          r_print_req    <= 1'b0;
          if (w_pop) begin
            if (w_head_legal) begin
              r_instr_valid  <= 1'b1;
              r_instr_n      <= w_head_n;
              r_instr_addr   <= w_head_addr;
              r_data_sel     <= (w_head_n != 4'd2);
              r_is_access    <= (w_head_n <= 4'd2);
              r_issued_count <= r_issued_count + 16'd1;
            end else if (r_err_count != 8'hFF) begin
              r_err_count    <= r_err_count + 8'd1;
            end
            case (w_head_n)
              4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                r_state       <= S_LOOKUP;
                r_read_enable <= 1'b1;
              end
              4'd8: begin
                r_state     <= S_CLEAR;
                r_clear_req <= 1'b1;
              end
              4'd9: begin
                r_state     <= S_PRINT1;
                r_print_req <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign o_cmd_ready    = r_cmd_ready;
  assign o_instr_valid  = r_instr_valid;
  assign o_instr_n      = r_instr_n;
  assign o_instr_addr   = r_instr_addr;
  assign o_instr_tag    = r_instr_addr[31 -: TAG_BITS];
  assign o_instr_index  = r_instr_addr[OFFSET_BITS +: INDEX_BITS];
  assign o_instr_offset = r_instr_addr[OFFSET_BITS-1:0];
  assign o_data_sel     = r_data_sel;
  assign o_read_enable  = r_read_enable;
  assign o_write_enable = r_write_enable;
  assign o_start        = r_start;
  assign o_clear_req    = r_clear_req;
  assign o_print_req    = r_print_req;
  assign o_busy         = (r_count != '0) | (r_state != S_IDLE);
  assign o_issued_count = r_issued_count;
  assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_trace_cmd_issuer.sv
// Bench for trace_cmd_issuer: a queue-of-phases model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_trace_cmd_issuer;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        i_cmd_valid, o_cmd_ready;
  logic [3:0]  i_cmd_n;
  logic [31:0] i_cmd_addr;
  logic        o_instr_valid;
  logic [3:0]  o_instr_n;
  logic [31:0] o_instr_addr;
  logic [11:0] o_instr_tag;
  logic [13:0] o_instr_index;
  logic [5:0]  o_instr_offset;
  logic        o_data_sel, o_read_enable, o_write_enable, o_start;
  logic        o_clear_req, o_print_req, o_busy;
  logic [15:0] o_issued_count;
  logic [7:0]  o_err_count;

  trace_cmd_issuer #(.FIFO_DEPTH(DEPTH), .INDEX_BITS(14), .OFFSET_BITS(6)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_n(i_cmd_n), .i_cmd_addr(i_cmd_addr),
    .o_instr_valid(o_instr_valid), .o_instr_n(o_instr_n), .o_instr_addr(o_instr_addr),
    .o_instr_tag(o_instr_tag), .o_instr_index(o_instr_index), .o_instr_offset(o_instr_offset),
    .o_data_sel(o_data_sel), .o_read_enable(o_read_enable), .o_write_enable(o_write_enable),
    .o_start(o_start), .o_clear_req(o_clear_req), .o_print_req(o_print_req),
    .o_busy(o_busy), .o_issued_count(o_issued_count), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each legal command expands into a list of per-cycle phases; the head phase is what
  // the outputs must show. When the list runs out, the next buffered command expands.
  typedef struct { bit re, we, st, clr, prt; bit [3:0] n; bit [31:0] addr; } phase_t;
  typedef struct { bit [3:0] n; bit [31:0] a; } cmd_t;

  phase_t      cur_q[$];
  cmd_t        fifo_q[$];
  bit          m_ready, m_started, m_push;
  bit [15:0]   m_issued;
  bit [7:0]    m_err;
  cmd_t        m_inc, m_c;
  phase_t      ph_e;
  bit          exp_valid;
  bit          seen7;
  logic [31:0] seen_q[$];
  bit          stall;

  function automatic void expand(input cmd_t c);
    phase_t p;
    p = '{default: 0};
    p.n = c.n;
    p.addr = c.a;
    if (c.n <= 6) begin
      p.re = 1; cur_q.push_back(p);
      p.re = 0; p.we = 1; p.st = (c.n <= 2); cur_q.push_back(p);
      m_issued++;
    end else if (c.n == 8) begin
      p.clr = 1; cur_q.push_back(p);
      m_issued++;
    end else if (c.n == 9) begin
      p.prt = 1; cur_q.push_back(p); cur_q.push_back(p);
      m_issued++;
    end else if (m_err != 8'd255) begin
      m_err++;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cur_q.delete();
      fifo_q.delete();
      m_ready = 0; m_issued = 0; m_err = 0; m_started = 1;
    end else begin
      m_push = i_cmd_valid && m_ready;
      m_inc.n = i_cmd_n;
      m_inc.a = i_cmd_addr;
      if (cur_q.size() != 0) void'(cur_q.pop_front());
      if (cur_q.size() == 0 && fifo_q.size() != 0) begin
        m_c = fifo_q.pop_front();
        expand(m_c);
      end
      if (m_push) fifo_q.push_back(m_inc);
      m_ready = (fifo_q.size() != DEPTH);
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      exp_valid = (cur_q.size() != 0);
      if (exp_valid) ph_e = cur_q[0];
      else ph_e = '{default: 0};
      check("cmd_ready", o_cmd_ready, m_ready);
      check("instr_valid", o_instr_valid, exp_valid);
      check("read_enable", o_read_enable, ph_e.re);
      check("write_enable", o_write_enable, ph_e.we);
      check("start", o_start, ph_e.st);
      check("clear_req", o_clear_req, ph_e.clr);
      check("print_req", o_print_req, ph_e.prt);
      check("busy", o_busy, (fifo_q.size() != 0) || exp_valid);
      check("issued_count", o_issued_count, m_issued);
      check("err_count", o_err_count, m_err);
      if (exp_valid) begin
        check("instr_n", o_instr_n, ph_e.n);
        check("instr_addr", o_instr_addr, ph_e.addr);
        check("instr_tag", o_instr_tag, ph_e.addr >> 20);
        check("instr_index", o_instr_index, (ph_e.addr >> 6) % 16384);
        check("instr_offset", o_instr_offset, ph_e.addr % 64);
      end
      if (ph_e.re || ph_e.we) check("data_sel", o_data_sel, ph_e.n != 4'd2);
      if (o_instr_valid === 1'b1 && o_instr_n == 4'd7) seen7 = 1;
      if (o_read_enable === 1'b1) seen_q.push_back(o_instr_addr);
    end
  end

  // Called at a negedge; returns at the negedge right after the edge that accepted the command.
  task automatic push(input logic [3:0] n, input logic [31:0] a);
    i_cmd_valid = 1; i_cmd_n = n; i_cmd_addr = a;
    for (int i = 0; i < 50; i++) begin
      if (o_cmd_ready) break;
      stall = 1;
      @(negedge clk);
    end
    check("push_ready", o_cmd_ready, 1);
    @(negedge clk);
  endtask

  task automatic drop_valid();
    i_cmd_valid = 0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (!o_busy) break;
      @(negedge clk);
    end
    check("idle_timeout", o_busy, 0);
  endtask

  int          vcnt, first_v, last_v, st_cnt, ds_i, clr_cnt, prt_cnt, rw_cnt;
  logic        ds[2];
  logic [31:0] exp_addrs[$];

  initial begin
    clk = 0; rst = 1; i_cmd_valid = 0; i_cmd_n = 0; i_cmd_addr = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", o_cmd_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_issued", o_issued_count, 0);
    rst = 0;
    @(negedge clk);
    check("ready_after_rst", o_cmd_ready, 1);

    // Single data read: lookup one cycle after pop; index = addr[19:6] = 0x3784.
    push(4'd0, 32'h984DE132);
    drop_valid();
    @(negedge clk);
    check("t1_re", o_read_enable, 1);
    check("t1_we", o_write_enable, 0);
    check("t1_tag", o_instr_tag, 12'h984);
    check("t1_index", o_instr_index, 14'h3784);
    check("t1_offset", o_instr_offset, 6'h32);
    check("t1_data_sel", o_data_sel, 1);
    @(negedge clk);
    check("t1_upd_we", o_write_enable, 1);
    check("t1_upd_start", o_start, 1);
    @(negedge clk);
    check("t1_idle_valid", o_instr_valid, 0);
    check("t1_issued", o_issued_count, 1);

    // Back-to-back fetch then write: four valid cycles with no bubble.
    push(4'd2, 32'h116DE12F);
    push(4'd1, 32'h100DE130);
    drop_valid();
    vcnt = 0; first_v = -1; last_v = -1; st_cnt = 0; ds_i = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_instr_valid) begin
        vcnt++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (o_start) st_cnt++;
      if (o_read_enable && ds_i < 2) begin ds[ds_i] = o_data_sel; ds_i++; end
      @(negedge clk);
    end
    check("t2_valid_cycles", vcnt, 4);
    check("t2_no_bubble", last_v - first_v + 1, 4);
    check("t2_start_pulses", st_cnt, 2);
    check("t2_ds_first", ds[0], 0);
    check("t2_ds_second", ds[1], 1);

    // Snoop: update phase writes but leaves the LRU alone.
    push(4'd4, 32'h777DE133);
    drop_valid();
    @(negedge clk);
    check("t3_re", o_read_enable, 1);
    @(negedge clk);
    check("t3_we", o_write_enable, 1);
    check("t3_start", o_start, 0);
    wait_idle(10);

    // Clear then print.
    push(4'd8, 32'h0);
    push(4'd9, 32'h0);
    drop_valid();
    clr_cnt = 0; prt_cnt = 0; rw_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_clear_req) clr_cnt++;
      if (o_print_req) prt_cnt++;
      if (o_read_enable || o_write_enable) rw_cnt++;
      @(negedge clk);
    end
    check("t4_clear_cycles", clr_cnt, 1);
    check("t4_print_cycles", prt_cnt, 2);
    check("t4_no_rw", rw_cnt, 0);

    // Illegal opcode dropped, following read issues normally.
    seen7 = 0;
    push(4'd7, 32'hDEADBEEF);
    push(4'd0, 32'h645DE10A);
    drop_valid();
    wait_idle(20);
    check("t5_err", o_err_count, 1);
    check("t5_no_op7", seen7, 0);
    check("t5_issued", o_issued_count, 7);
    check("t5_addr", o_instr_addr, 32'h645DE10A);

    // Stream nine commands: FIFO fills, ready stalls, order is preserved across pointer wrap.
    seen_q.delete();
    exp_addrs.delete();
    stall = 0;
    for (int i = 0; i < 9; i++) begin
      exp_addrs.push_back(32'hA000_0000 + 32'(i) * 32'h40);
      push(4'(i % 2), 32'hA000_0000 + 32'(i) * 32'h40);
    end
    drop_valid();
    wait_idle(40);
    check("t6_stalled", stall, 1);
    check("t6_count", seen_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < seen_q.size()) check("t6_order", seen_q[i], exp_addrs[i]);
    end
    check("t6_issued", o_issued_count, 16);

    // Reset mid-update drops the command in flight and everything buffered.
    push(4'd1, 32'hB000_0040);
    push(4'd0, 32'hB000_0080);
    push(4'd0, 32'hB000_00C0);
    drop_valid();
    for (int i = 0; i < 10; i++) begin
      if (o_write_enable) break;
      @(negedge clk);
    end
    check("t7_in_update", o_write_enable, 1);
    rst = 1;
    @(negedge clk);
    check("t7_rst_valid", o_instr_valid, 0);
    check("t7_rst_we", o_write_enable, 0);
    check("t7_rst_start", o_start, 0);
    check("t7_rst_busy", o_busy, 0);
    check("t7_rst_ready", o_cmd_ready, 0);
    check("t7_rst_addr", o_instr_addr, 0);
    check("t7_rst_issued", o_issued_count, 0);
    check("t7_rst_err", o_err_count, 0);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    check("t7_post_busy", o_busy, 0);
    push(4'd2, 32'h1234_5678);
    drop_valid();
    wait_idle(10);
    check("t7_post_issued", o_issued_count, 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
